imem_fetch_ctrl: RTL and testbench

Sequencer that owns the instruction memory. After reset it boot-loads a program into the memory through a streaming load port. It then runs a word-addressed fetch loop that presents one registered instruction per cycle to decode, with support for stall, redirect (jump/branch) and out-of-range halt. It sits between the loader/testbench, the instruction memory array and the decode stage.

---
 rtl/imem_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boot-loads the program through a streaming port, then fetches one word per cycle.
// Optional IFETCH_PERF_EN macro adds saturating fetch_count / stall_count outputs.
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH    = 50,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  // Load port: a word transfers on a rising edge where load_valid && load_ready.
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [1:0]  state,
  output logic        error
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        error_q, error_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      count_q       <= 32'd0;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    error_d       = error_q;
    load_ready    = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = count_q;
    mem_wdata     = load_data;
    mem_raddr     = 32'd0;
    case (state_q)
      ST_BOOT: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we  = 1'b1;
          count_d = count_q + 32'd1;
          // The memory filling up ends boot even without load_last.
          if (load_last || count_q == LAST_ADDR) begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
          end
        end
      end
      ST_RUN: begin
        mem_raddr = pc_q;
        if (redirect) begin
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          if (pc_q >= DEPTH_W) begin
            error_d       = 1'b1;
            instr_valid_d = 1'b0;
            state_d       = ST_HALT;
          end else begin
            instr_d       = mem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd1;
          end
        end
      end
      default: begin
        mem_raddr     = pc_q;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign state       = state_q;
  assign error       = error_q;

`ifdef IFETCH_PERF_EN
  logic        fetch_inc, stall_inc;
  logic [31:0] fetch_count_q, stall_count_q;

  assign fetch_inc = (state_q == ST_RUN) && !redirect && !stall && (pc_q < DEPTH_W);
  assign stall_inc = (state_q == ST_RUN) && stall && !redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (fetch_inc && fetch_count_q != 32'hFFFF_FFFF) fetch_count_q <= fetch_count_q + 32'd1;
      if (stall_inc && stall_count_q != 32'hFFFF_FFFF) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed boot/run/halt/reset cases plus randomized fetch traffic
// against a program-level reference model and an instruction-stream scoreboard.
module tb_imem_fetch_ctrl;
  localparam int          DEPTH    = 4;
  localparam int          AW       = 2;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0, load_last = 1'b0, load_ready;
  logic [31:0] load_data = 32'd0;
  logic        mem_we;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, error;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] prog [DEPTH];
  logic [31:0] mem  [DEPTH];
  logic        mem_init = 1'b1;

  int          m_state;
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_err;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .state(state), .error(error)
  );

  always #5 clock = ~clock;

  // Instruction memory array: combinational read, written on the clock edge.
  always_comb mem_rdata = (mem_raddr < 32'(DEPTH)) ? mem[mem_raddr[AW-1:0]] : 32'd0;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 + 32'(i);
    end else if (mem_we && mem_waddr < 32'(DEPTH)) begin
      mem[mem_waddr[AW-1:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = RESET_PC;
    m_instr = 32'd0;
    m_ipc   = 32'd0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // Monitor: every valid instruction presented must match the next expected entry.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (!reset && instr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h instr %h, required no valid instruction", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr_pc", instr_pc, e[63:32]);
          chk("sb_instr", instr, e[31:0]);
        end
      end
    end
  end

  task automatic boot(input int n, input bit use_last, input bit directed);
    int exp_st;
    for (int i = 0; i < n; i++) begin
      load_valid  = 1'b1;
      load_data   = directed ? 32'(i + 1) * 32'h11 : $urandom;
      load_last   = use_last && (i == n - 1);
      stall       = 1'($urandom_range(0, 1));
      redirect    = 1'($urandom_range(0, 1));
      redirect_pc = 32'($urandom_range(0, 7));
      #1;
      chk("boot_load_ready", 32'(load_ready), 32'd1);
      chk("boot_mem_we", 32'(mem_we), 32'd1);
      chk("boot_mem_waddr", mem_waddr, 32'(i));
      chk("boot_mem_wdata", mem_wdata, load_data);
      chk("boot_mem_raddr", mem_raddr, 32'd0);
      prog[i] = load_data;
      @(posedge clock);
      #1;
      exp_st = ((i == n - 1) && (use_last || n == DEPTH)) ? 1 : 0;
      chk("boot_state", 32'(state), 32'(exp_st));
      chk("boot_instr_valid", 32'(instr_valid), 32'd0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    if (use_last || n == DEPTH) begin
      m_state = 1;
      m_pc    = RESET_PC;
    end
  endtask

  // One fetch cycle: apply inputs, predict from program-level rules, check the registered result.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic lv);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    load_valid  = lv;
    load_data   = $urandom;
    load_last   = 1'($urandom_range(0, 1));
    #1;
    chk("ignored_load_ready", 32'(load_ready), 32'd0);
    chk("ignored_mem_we", 32'(mem_we), 32'd0);
    if (m_state == 1) chk("mem_raddr_pc", mem_raddr, m_pc);
    if (m_state == 1) begin
      if (r) begin
        m_pc    = rpc;
        m_valid = 1'b0;
      end else if (!s) begin
        if (m_pc >= 32'(DEPTH)) begin
          m_err   = 1'b1;
          m_valid = 1'b0;
          m_state = 2;
        end else begin
          m_instr = prog[m_pc[AW-1:0]];
          m_ipc   = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd1;
        end
      end
    end
    if (m_valid) exp_q.push_back({m_ipc, m_instr});
    @(posedge clock);
    #1;
    chk("run_state", 32'(state), 32'(m_state));
    chk("run_error", 32'(error), 32'(m_err));
    chk("run_instr_valid", 32'(instr_valid), 32'(m_valid));
  endtask

  task automatic phase_end();
    load_valid = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    @(negedge clock);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("areset_state", 32'(state), 32'd0);
    chk("areset_error", 32'(error), 32'd0);
    chk("areset_instr_valid", 32'(instr_valid), 32'd0);
    chk("areset_load_ready", 32'(load_ready), 32'd1);
    model_reset();
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ul;
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'hA5A5_0000 + 32'(i);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    mem_init = 1'b0;
    reset    = 1'b0;

    // Three-word program ended by load_last, then run, stall, redirect and overrun into HALT.
    boot(3, 1'b1, 1'b1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 32'd0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 1, 32'd1, 1);
    phase_end();
    async_reset();

    // Full-depth boot without load_last; the following load offer must be refused.
    boot(DEPTH, 1'b0, 1'b0);
    step(0, 0, 0, 1);
    step(0, 1, 32'd6, 0);
    step(0, 0, 0, 0);
    phase_end();
    async_reset();

    // Reset in the middle of a boot restarts the load count at zero.
    boot(2, 1'b0, 1'b0);
    async_reset();
    boot(DEPTH, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    phase_end();

    for (int it = 0; it < 12; it++) begin
      async_reset();
      n  = $urandom_range(1, DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      boot(n, ul, 1'b0);
      for (int k = 0; k < 30; k++) begin
        step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) < 3),
             32'($urandom_range(0, DEPTH + 1)), 1'($urandom_range(0, 1)));
      end
      phase_end();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
